// File: rtl/rgb_palette_packer.sv
// Quantises 24-bit RGB pixels to 3-bit colour codes and packs PIX_PER_WORD codes
// per output word, flushing a partial word at end of line.
module rgb_palette_packer #(
  parameter int          PIX_PER_WORD = 8,
  parameter logic [7:0]  THRESH       = 8'h80,
  localparam int         DW           = 3 * PIX_PER_WORD,
  localparam int         CW           = $clog2(PIX_PER_WORD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_r,
  input  logic [7:0]    in_g,
  input  logic [7:0]    in_b,
  input  logic          in_eol,
  input  logic          line_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_eol
);

  typedef enum logic {EMPTY, FILLING} state_t;

  function automatic logic [2:0] quantise(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    return {r >= THRESH, g >= THRESH, b >= THRESH};
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_eol_q, out_eol_d;

  logic          in_xfer;
  logic [2:0]    code;
  logic [CW-1:0] base_cnt;
  logic [DW-1:0] base_acc;
  logic [DW-1:0] ins;
  logic          complete;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_eol   = out_eol_q;

  always_comb begin
    in_xfer = in_valid && in_ready;
    code    = quantise(in_r, in_g, in_b);
    // line_clr takes effect before a same-cycle pixel, so that pixel lands in slot 0
    base_cnt = (line_clr || state_q == EMPTY) ? '0 : cnt_q;
    base_acc = line_clr ? '0 : acc_q;
    ins      = base_acc;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (base_cnt == CW'(k)) ins[3*k +: 3] = code;
    end
    complete = in_xfer && (in_eol || base_cnt == CW'(PIX_PER_WORD - 1));

    cnt_d       = base_cnt;
    acc_d       = base_acc;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_eol_d   = out_eol_q;

    if (complete) begin
      // in_xfer guarantees the output register is empty or being drained this edge
      out_valid_d = 1'b1;
      out_data_d  = ins;
      out_count_d = base_cnt + CW'(1);
      out_eol_d   = in_eol;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (in_xfer) begin
      cnt_d = base_cnt + CW'(1);
      acc_d = ins;
    end

    state_d = (cnt_d == '0) ? EMPTY : FILLING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_eol_q   <= out_eol_d;
    end
  end

endmodule

// File: tb/tb_rgb_palette_packer.sv
// Directed bench for rgb_palette_packer with PIX_PER_WORD=8, THRESH=8'h80.
module tb_rgb_palette_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_eol;
  logic        line_clr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [3:0]  out_count;
  logic        out_eol;

  int tests = 0;
  int fails = 0;

  rgb_palette_packer #(.PIX_PER_WORD(8), .THRESH(8'h80)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_eol(in_eol), .line_clr(line_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] chan(input logic on);
    return on ? 8'hFF : 8'h00;
  endfunction

  // Drives one pixel for one clock edge; caller ensures in_ready is high.
  task automatic push_raw(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic eol, input logic clr);
    in_valid = 1'b1; in_r = r; in_g = g; in_b = b; in_eol = eol; line_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_eol = 1'b0; line_clr = 1'b0;
    in_r = 8'hAA; in_g = 8'hAA; in_b = 8'hAA;
  endtask

  task automatic push(input logic [2:0] c, input logic eol);
    push_raw(chan(c[2]), chan(c[1]), chan(c[0]), eol, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 24'h0) begin fails++; $display("FAIL reset_out_data got %h exp 000000", out_data); end
    tests++; if (out_count !== 4'd0) begin fails++; $display("FAIL reset_out_count got %0d exp 0", out_count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_full_word;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) push(3'(k), 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid got %b exp 0", out_valid); end
    push(3'd7, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 24'hFAC688) begin fails++; $display("FAIL full_data got %h exp FAC688", out_data); end
    tests++; if (out_count !== 4'd8) begin fails++; $display("FAIL full_count got %0d exp 8", out_count); end
    tests++; if (out_eol !== 1'b0) begin fails++; $display("FAIL full_eol got %b exp 0", out_eol); end
    idle(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_short_line;
    push(3'd7, 1'b0);
    push(3'd7, 1'b0);
    push(3'd7, 1'b1);
    tests++; if (out_data !== 24'h0001FF) begin fails++; $display("FAIL short_data got %h exp 0001FF", out_data); end
    tests++; if (out_count !== 4'd3) begin fails++; $display("FAIL short_count got %0d exp 3", out_count); end
    tests++; if (out_eol !== 1'b1) begin fails++; $display("FAIL short_eol got %b exp 1", out_eol); end
    idle(1);
  endtask

  task automatic test_threshold;
    push_raw(8'h80, 8'h7F, 8'hFF, 1'b1, 1'b0);
    tests++; if (out_data !== 24'h000005) begin fails++; $display("FAIL thresh_data got %h exp 000005", out_data); end
    tests++; if (out_count !== 4'd1) begin fails++; $display("FAIL thresh_count got %0d exp 1", out_count); end
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    push(3'd7, 1'b1);
    in_valid = 1'b1; in_r = 8'h00; in_g = 8'hFF; in_b = 8'hFF; in_eol = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 24'h000007 || out_count !== 4'd1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc %0d got v=%b d=%h c=%0d r=%b exp v=1 d=000007 c=1 r=0",
                 i, out_valid, out_data, out_count, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_eol = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 24'h000003) begin fails++; $display("FAIL b2b_data got %h exp 000003", out_data); end
    tests++; if (out_count !== 4'd1) begin fails++; $display("FAIL b2b_count got %0d exp 1", out_count); end
    idle(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_line_clr;
    for (int k = 0; k < 4; k++) push(3'd1, 1'b0);
    push_raw(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL clr_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 24'h000006) begin fails++; $display("FAIL clr_data got %h exp 000006", out_data); end
    tests++; if (out_count !== 4'd1) begin fails++; $display("FAIL clr_count got %0d exp 1", out_count); end
    tests++; if (out_eol !== 1'b1) begin fails++; $display("FAIL clr_eol got %b exp 1", out_eol); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    // Held word killed by async reset
    out_ready = 1'b0;
    push(3'd5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 24'h0 || out_count !== 4'd0 || out_eol !== 1'b0)
      begin fails++; $display("FAIL rst_held got v=%b d=%h c=%0d e=%b exp all 0", out_valid, out_data, out_count, out_eol); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    // Partial word of 5 pixels killed by reset
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(3'd4, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    push(3'd2, 1'b0);
    push(3'd1, 1'b1);
    tests++; if (out_count !== 4'd2) begin fails++; $display("FAIL rst_post_count got %0d exp 2", out_count); end
    tests++; if (out_data !== 24'h00000A) begin fails++; $display("FAIL rst_post_data got %h exp 00000A", out_data); end
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0;
    in_eol = 1'b0; line_clr = 1'b0; out_ready = 1'b1;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_full_word();
    test_short_line();
    test_threshold();
    test_backpressure();
    test_line_clr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_palette_packer.md
Name: rgb_palette_packer

Overview:
- Inverse of the 3-bit palette lookup. Takes a 24-bit RGB pixel stream from the capture/scaler path and quantises each pixel to a 3-bit colour code.
- Packs codes into fixed-width words for the display framebuffer writer.
- Input and output both use valid/ready handshakes. A partial word is flushed at end of line.

Parameters:
- PIX_PER_WORD, 8, number of 3-bit codes packed per output word (2..10).
- THRESH, 8'h80, per-channel threshold; channel bit = 1 when channel value >= THRESH (unsigned compare).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_r  in  8  red channel.
- in_g  in  8  green channel.
- in_b  in  8  blue channel.
- in_eol  in  1  qualifies in_valid; pixel is the last of its line.
- line_clr  in  1  synchronous 1-cycle pulse; discards the partial word (start of frame/resync).
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  3*PIX_PER_WORD  packed codes; pixel k at bits [3k+2:3k].
- out_count  out  clog2(PIX_PER_WORD+1)  number of valid pixels in out_data (1..PIX_PER_WORD).
- out_eol  out  1  word ends a line.

Behaviour:
- Code mapping: code = {in_r>=THRESH, in_g>=THRESH, in_b>=THRESH}; bit2 = R, bit0 = B. Examples: white -> 3'b111, pure red -> 3'b100.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
- in_ready = !out_valid || out_ready. The input stalls only while a held word is not being taken. in_ready is combinational from out_ready.
- Accumulator: fill register acc[3*PIX_PER_WORD-1:0] plus fill count cnt (0..PIX_PER_WORD-1). An accepted pixel is written to slot cnt.
- Word completion: a word completes when the accepted pixel lands in slot PIX_PER_WORD-1, or when in_eol=1.
  - On completion, the next edge loads the output register: out_data = acc with the new code inserted and unused upper slots = 0, out_count = cnt+1, out_eol = in_eol.
  - On the same edge, out_valid is set, cnt returns to 0 and acc clears.
  - Latency: out_valid is high on the cycle after the completing input transfer.
- Non-completing pixel: cnt increments; no output change.
- Output hold: the output register holds data, count and eol stable while out_valid && !out_ready.
  - out_valid clears after an output transfer, unless a new word loads on the same edge. In that case out_valid stays 1 with the new contents, giving back-to-back words with no bubble.
- State machine on cnt: EMPTY (cnt=0) and FILLING (cnt>0).
  - EMPTY -> FILLING on an accepted non-completing pixel.
  - FILLING -> EMPTY on completion or line_clr.
  - The output register is an independent valid flag.
- line_clr:
  - Zeroes cnt and acc.
  - Never touches a word already in the output register.
  - If a pixel is accepted in the same cycle, line_clr is applied first, so that pixel becomes slot 0. If that pixel also has in_eol=1, a 1-pixel word is emitted.
- in_eol when cnt=0: emits a word with out_count=1.
- in_eol on slot PIX_PER_WORD-1: a single full word with out_eol=1; no extra empty word.
- in_valid=0: in_r, in_g, in_b and in_eol are ignored. No spurious accumulation.
- Reset (async assert, sync deassert handled externally):
  - out_valid=0, out_data=0, out_count=0, out_eol=0, cnt=0, acc=0.
  - in_ready=1 after reset (out_valid=0).
  - Reset mid-word discards the partial word and any held output.

Test Plan:
- Full word: PIX_PER_WORD=8, out_ready=1, 8 pixels with codes 0..7 (e.g. pixel 5 = R=FF,G=00,B=FF), no eol -> one word, out_data=24'hFAC688, out_count=8, out_eol=0, one cycle after the 8th transfer.
- Short line: 3 white pixels with eol on the 3rd -> out_data=24'h0001FF, out_count=3, out_eol=1; cnt back to 0.
- Threshold edges: R=8'h80,G=8'h7F,B=8'hFF single pixel with eol -> code 3'b101, out_data=24'h000005, out_count=1.
- Backpressure: out_ready=0 with one word held, in_valid=1 -> in_ready=0, out_data stable across 5 cycles.
  - Then raise out_ready together with completing a new word -> out_valid stays 1, new word follows with no gap and no lost pixel.
- line_clr: 4 pixels, then line_clr in the same cycle as a pixel with eol -> one word, out_count=1, containing only that pixel.
- Reset mid-operation: assert rst_n=0 with cnt=5 and out_valid=1 -> all outputs zero immediately; after release, a 2-pixel eol line yields out_count=2.
